framebuffer_row_fetch: RTL

// - Reader for the display side (16-bit port B) of the dual-port framebuffer; host writes via the 8-bit port.
// - On a row request, fetches COLUMNS consecutive 16-bit words and presents them as a valid/ready pixel stream.
// - Feeds the panel shift-out logic. Sustains 1 pixel/clk. Absorbs RAM read latency and downstream backpressure.

---
 rtl/framebuffer_pkg.sv | 25 ++
 rtl/pixel_skid_fifo.sv | 69 ++++++
 rtl/framebuffer_row_fetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/framebuffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_pkg
//  Purpose  : Shared defaults and types for the framebuffer display-side
//             row fetcher.
//  Contents : FB_ADDR_W / FB_DATA_W / FB_COLUMNS / FB_ROWS defaults,
//             fetch_state_t row-fetch FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package framebuffer_pkg;

   localparam int FB_ADDR_W  = 11;   // port B word-address width
   localparam int FB_DATA_W  = 16;   // one pixel per word
   localparam int FB_COLUMNS = 64;   // pixels per row, power of 2
   localparam int FB_ROWS    = 32;   // FB_ROWS*FB_COLUMNS == 2**FB_ADDR_W

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

endpackage : framebuffer_pkg
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_skid_fifo
//  Purpose  : Two-entry FIFO between the RAM read port and the pixel stream.
//             The head entry is a register so the output is glitch-free and
//             holds steady under backpressure.
//  Ports    : clk, rst_n      - clock, async active-low reset
//             push, push_data - write one entry
//             pop             - remove head entry (ignored when empty)
//             head_data       - registered head entry
//             count           - occupancy 0..2
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_skid_fifo #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] tail_q;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != 2'd0);
   // A push into a full FIFO is only accepted when a pop frees a slot.
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_data <= '0;
         tail_q    <= '0;
         count     <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_data <= push_data;
               end else begin
                  tail_q <= push_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_data <= tail_q;
               count     <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind whatever remains.
               if (count == 2'd2) begin
                  head_data <= tail_q;
                  tail_q    <= push_data;
               end else begin
                  head_data <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : pixel_skid_fifo
`default_nettype wire

// File: rtl/framebuffer_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_row_fetch
//  Purpose  : Display-side reader of the dual-port framebuffer. On a row
//             request it reads COLUMNS consecutive words from port B and
//             presents them as a valid/ready pixel stream at up to 1 px/clk.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             row_start, row_sel         - row request (sampled in IDLE)
//             busy                       - request accepted, row not done
//             mem_address, mem_clock_en  - port B read request
//             mem_q                      - port B data, 1 clk after strobe
//             pixel_data/valid/ready/last- output pixel stream
//             row_done                   - 1-clk pulse after last handshake
//  Revision : 1.0 - initial release
// ============================================================================
module framebuffer_row_fetch
   import framebuffer_pkg::*;
#(
   parameter int ADDR_W  = FB_ADDR_W,
   parameter int DATA_W  = FB_DATA_W,
   parameter int COLUMNS = FB_COLUMNS,
   parameter int ROWS    = FB_ROWS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    row_start,
   input  logic [$clog2(ROWS)-1:0] row_sel,
   output logic                    busy,
   output logic [ADDR_W-1:0]       mem_address,
   output logic                    mem_clock_en,
   input  logic [DATA_W-1:0]       mem_q,
   output logic [DATA_W-1:0]       pixel_data,
   output logic                    pixel_valid,
   input  logic                    pixel_ready,
   output logic                    pixel_last,
   output logic                    row_done
);

   localparam int COL_W = $clog2(COLUMNS);
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic             inflight;       // read issued last cycle, data on mem_q now
   logic             inflight_last;  // that read was the row's final column
   logic [1:0]       count;
   logic [DATA_W:0]  head;
   logic             pop;
   logic             col_last;
   logic             room;

   assign col_last = (col_q == LAST_COL);
   assign pop      = pixel_valid && pixel_ready;
   // Never let buffered plus outstanding words exceed the two FIFO slots;
   // a pop in the same cycle frees the slot the new read will need.
   assign room     = ((count + {1'b0, inflight}) < 2'd2) || pop;

   always_comb begin
      state_nxt    = state;
      mem_clock_en = 1'b0;
      case (state)
         IDLE: begin
            if (row_start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            mem_clock_en = room;
            if (room && col_last) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Leave as soon as the final pop empties the buffer, so the
            // done pulse follows the last handshake directly.
            if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_nxt;
         inflight      <= mem_clock_en;
         inflight_last <= mem_clock_en && col_last;
         if ((state == IDLE) && row_start) begin
            row_q <= row_sel;
            col_q <= '0;
         end else if (mem_clock_en && !col_last) begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   assign mem_address = {row_q, col_q};

   pixel_skid_fifo #(
      .WIDTH(DATA_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data ({inflight_last, mem_q}),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   assign pixel_valid = (count != 2'd0);
   assign pixel_data  = head[DATA_W-1:0];
   assign pixel_last  = head[DATA_W] && pixel_valid;
   assign busy        = (state != IDLE);
   assign row_done    = (state == DONE);

endmodule : framebuffer_row_fetch
`default_nettype wire
